// File: rtl/max7219_pkg.sv
// Shared MAX7219 definitions: register addresses, FSM encoding and frame payload.
package max7219_pkg;

    localparam int unsigned ADDR_W     = 4;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned SHIFT_W    = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned NUM_DIGITS = 8;

    localparam logic [ADDR_W-1:0] NOOP      = 4'h0;
    localparam logic [ADDR_W-1:0] DIGIT0    = 4'h1;
    localparam logic [ADDR_W-1:0] DIGIT1    = 4'h2;
    localparam logic [ADDR_W-1:0] DIGIT2    = 4'h3;
    localparam logic [ADDR_W-1:0] DIGIT3    = 4'h4;
    localparam logic [ADDR_W-1:0] DIGIT4    = 4'h5;
    localparam logic [ADDR_W-1:0] DIGIT5    = 4'h6;
    localparam logic [ADDR_W-1:0] DIGIT6    = 4'h7;
    localparam logic [ADDR_W-1:0] DIGIT7    = 4'h8;
    localparam logic [ADDR_W-1:0] DECODE    = 4'h9;
    localparam logic [ADDR_W-1:0] INTENSITY = 4'hA;
    localparam logic [ADDR_W-1:0] SCANLIMIT = 4'hB;
    localparam logic [ADDR_W-1:0] SHUTDOWN  = 4'hC;
    localparam logic [ADDR_W-1:0] TEST      = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } frame_t;

    // Bit counter increment that holds at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

endpackage

// File: rtl/sc_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall detection
// on the synchronised level.
module sc_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q      = sync[STAGES-1];
    assign rise_c = sync[STAGES-1] & ~prev;
    assign fall_c = ~sync[STAGES-1] & prev;

endmodule

// File: rtl/max7219_receiver.sv
// MAX7219-compatible serial receiver: oversamples din/ncs/clk with the system
// clock, assembles 16-bit frames and decodes them into the display registers.
module max7219_receiver
    import max7219_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FRAME_BITS  = 16
) (
    input  logic              MAX7219_RECEIVER_CLOCK_50,
    input  logic              MAX7219_RECEIVER_RESET_InHigh,
    input  logic              max7219_din,
    input  logic              max7219_ncs,
    input  logic              max7219_clk,
    input  logic [2:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_valid,
    output logic [ADDR_W-1:0] frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_error,
    output logic [7:0]        decode_mode,
    output logic [3:0]        intensity,
    output logic [2:0]        scan_limit,
    output logic              shutdown_n,
    output logic              display_test
);

    logic clk;
    logic rst;
    assign clk = MAX7219_RECEIVER_CLOCK_50;
    assign rst = MAX7219_RECEIVER_RESET_InHigh;

    logic din_q;
    logic ncs_rise;
    logic ncs_fall;
    logic sclk_rise;
    logic unused_din_rise;
    logic unused_din_fall;
    logic unused_ncs_q;
    logic unused_sclk_q;
    logic unused_sclk_fall;

    sc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_din (
        .clk    (clk),
        .rst    (rst),
        .d      (max7219_din),
        .q      (din_q),
        .rise_c (unused_din_rise),
        .fall_c (unused_din_fall)
    );

    sc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk    (clk),
        .rst    (rst),
        .d      (max7219_ncs),
        .q      (unused_ncs_q),
        .rise_c (ncs_rise),
        .fall_c (ncs_fall)
    );

    sc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .rst    (rst),
        .d      (max7219_clk),
        .q      (unused_sclk_q),
        .rise_c (sclk_rise),
        .fall_c (unused_sclk_fall)
    );

    state_t             state;
    state_t             next_state;
    logic [SHIFT_W-1:0] shift_q;
    logic [CNT_W-1:0]   count;
    logic [DATA_W-1:0]  digit [NUM_DIGITS];

    logic   enter_shift_c;
    logic   frame_ok_c;
    logic   frame_bad_c;
    frame_t frame_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the per-cycle strobes derived from it.
    always_comb begin
        next_state    = state;
        enter_shift_c = 1'b0;
        frame_ok_c    = 1'b0;
        frame_bad_c   = 1'b0;
        frame_c       = frame_t'(shift_q[ADDR_W+DATA_W-1:0]);
        unique case (state)
            IDLE: begin
                if (ncs_fall) begin
                    next_state    = SHIFT;
                    enter_shift_c = 1'b1;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    next_state = LATCH;
                end
            end
            LATCH: begin
                frame_ok_c  = (count == CNT_W'(FRAME_BITS));
                frame_bad_c = ~frame_ok_c;
                if (ncs_fall) begin
                    next_state    = SHIFT;
                    enter_shift_c = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Shift path, frame strobes and register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q      <= '0;
            count        <= '0;
            frame_valid  <= 1'b0;
            frame_error  <= 1'b0;
            frame_addr   <= '0;
            frame_data   <= '0;
            decode_mode  <= '0;
            intensity    <= '0;
            scan_limit   <= '0;
            shutdown_n   <= 1'b0;
            display_test <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit[i] <= '0;
            end
        end else begin
            frame_valid <= frame_ok_c;
            frame_error <= frame_bad_c;

            if (enter_shift_c) begin
                count <= '0;
            end else if (state == SHIFT && sclk_rise) begin
                shift_q <= SHIFT_W'({shift_q, din_q});
                count   <= sat_inc(count);
            end

            if (frame_ok_c) begin
                frame_addr <= frame_c.addr;
                frame_data <= frame_c.data;
                case (frame_c.addr)
                    NOOP:      ;
                    DIGIT0:    digit[0]     <= frame_c.data;
                    DIGIT1:    digit[1]     <= frame_c.data;
                    DIGIT2:    digit[2]     <= frame_c.data;
                    DIGIT3:    digit[3]     <= frame_c.data;
                    DIGIT4:    digit[4]     <= frame_c.data;
                    DIGIT5:    digit[5]     <= frame_c.data;
                    DIGIT6:    digit[6]     <= frame_c.data;
                    DIGIT7:    digit[7]     <= frame_c.data;
                    DECODE:    decode_mode  <= frame_c.data;
                    INTENSITY: intensity    <= frame_c.data[3:0];
                    SCANLIMIT: scan_limit   <= frame_c.data[2:0];
                    SHUTDOWN:  shutdown_n   <= frame_c.data[0];
                    TEST:      display_test <= frame_c.data[0];
                    default:   ;
                endcase
            end
        end
    end

    assign rd_data = digit[rd_addr];

endmodule

// File: tb/tb_max7219_receiver.sv
// Self-checking bench for max7219_receiver: directed and random frames against
// a behavioural register-file model.
module tb_max7219_receiver;

    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       ncs;
    logic       sclk;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_error;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n;
    logic       display_test;

    always #5 clk = ~clk;

    max7219_receiver #(.SYNC_STAGES(SYNC), .FRAME_BITS(16)) dut (
        .MAX7219_RECEIVER_CLOCK_50     (clk),
        .MAX7219_RECEIVER_RESET_InHigh (rst),
        .max7219_din                   (din),
        .max7219_ncs                   (ncs),
        .max7219_clk                   (sclk),
        .rd_addr                       (rd_addr),
        .rd_data                       (rd_data),
        .frame_valid                   (frame_valid),
        .frame_addr                    (frame_addr),
        .frame_data                    (frame_data),
        .frame_error                   (frame_error),
        .decode_mode                   (decode_mode),
        .intensity                     (intensity),
        .scan_limit                    (scan_limit),
        .shutdown_n                    (shutdown_n),
        .display_test                  (display_test)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    logic [11:0] acc_q[$];
    logic [11:0] exp_q[$];

    // Pulse monitor: one count per high cycle.
    always @(negedge clk) begin
        if (frame_valid) begin
            valid_cnt++;
            acc_q.push_back({frame_addr, frame_data});
        end
        if (frame_error) error_cnt++;
    end

    // Behavioural model of the register file.
    logic [7:0] m_digit [8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shut;
    logic       m_test;
    logic [3:0] m_faddr;
    logic [7:0] m_fdata;

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = 8'h00;
        m_decode = 0; m_int = 0; m_scan = 0; m_shut = 0; m_test = 0;
        m_faddr = 0; m_fdata = 0;
    endfunction

    function automatic void model_frame(input logic [31:0] bits, input int n);
        int a;
        logic [7:0] d;
        if (n != 16) return;
        a = int'(bits[11:8]);
        d = bits[7:0];
        m_faddr = bits[11:8];
        m_fdata = d;
        exp_q.push_back(bits[11:0]);
        if (a >= 1 && a <= 8) m_digit[a-1] = d;
        else if (a == 9)  m_decode = d;
        else if (a == 10) m_int = d[3:0];
        else if (a == 11) m_scan = d[2:0];
        else if (a == 12) m_shut = d[0];
        else if (a == 15) m_test = d[0];
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int n, input bit simul_last);
        for (int i = n - 1; i >= 0; i--) begin
            din = bits[i];
            wait_clk(2);
            if (i == 0 && simul_last) begin
                sclk = 1'b1;
                ncs  = 1'b1;
                wait_clk(3);
                sclk = 1'b0;
                return;
            end
            sclk = 1'b1;
            wait_clk(3);
            sclk = 1'b0;
            wait_clk(2);
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n, input bit simul_last);
        ncs = 1'b0;
        wait_clk(3);
        shift_bits(bits, n, simul_last);
        ncs = 1'b1;
        wait_clk(8);
        model_frame(bits, n);
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 0; ncs = 1; sclk = 0; rd_addr = 0;
        wait_clk(4);
        model_reset();
        n_checks += 9;
        if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset frame_valid got %0h exp 0", frame_valid); end
        if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset frame_error got %0h exp 0", frame_error); end
        if (frame_addr !== 4'h0) begin n_fail++; $display("FAIL reset frame_addr got %0h exp 0", frame_addr); end
        if (frame_data !== 8'h00) begin n_fail++; $display("FAIL reset frame_data got %0h exp 0", frame_data); end
        if (decode_mode !== 8'h00) begin n_fail++; $display("FAIL reset decode_mode got %0h exp 0", decode_mode); end
        if (intensity !== 4'h0) begin n_fail++; $display("FAIL reset intensity got %0h exp 0", intensity); end
        if (scan_limit !== 3'h0) begin n_fail++; $display("FAIL reset scan_limit got %0h exp 0", scan_limit); end
        if (shutdown_n !== 1'b0) begin n_fail++; $display("FAIL reset shutdown_n got %0h exp 0", shutdown_n); end
        if (display_test !== 1'b0) begin n_fail++; $display("FAIL reset display_test got %0h exp 0", display_test); end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset digit%0d got %0h exp 0", i, rd_data); end
        end
        rst = 1'b0;
        wait_clk(3);
    endtask

    task automatic test_intensity();
        int v0 = valid_cnt;
        int lat = 0;
        ncs = 1'b0;
        wait_clk(3);
        shift_bits(32'h0A05, 16, 1'b0);
        ncs = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid === 1'b1 && lat == 0) lat = k;
        end
        model_frame(32'h0A05, 16);
        n_checks += 5;
        if (lat != SYNC + 2) begin n_fail++; $display("FAIL latency got %0d exp %0d", lat, SYNC + 2); end
        if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL intensity valid_pulses got %0d exp 1", valid_cnt - v0); end
        if (intensity !== 4'h5) begin n_fail++; $display("FAIL intensity value got %0h exp 5", intensity); end
        if (frame_addr !== 4'hA) begin n_fail++; $display("FAIL intensity frame_addr got %0h exp a", frame_addr); end
        if (frame_data !== 8'h05) begin n_fail++; $display("FAIL intensity frame_data got %0h exp 05", frame_data); end
    endtask

    task automatic test_digits();
        logic [7:0] pat [8] = '{8'h81, 8'h42, 8'h24, 8'h3C, 8'hC3, 8'h66, 8'h99, 8'h18};
        int v0 = valid_cnt;
        for (int i = 0; i < 8; i++) send_frame({16'h0, 4'h0, 4'(i + 1), pat[i]}, 16, 1'b0);
        n_checks++;
        if (valid_cnt - v0 != 8) begin n_fail++; $display("FAIL digits valid_pulses got %0d exp 8", valid_cnt - v0); end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== m_digit[i]) begin n_fail++; $display("FAIL digits rd%0d got %0h exp %0h", i, rd_data, m_digit[i]); end
        end
    endtask

    task automatic test_bad_length();
        int v0 = valid_cnt;
        int e0 = error_cnt;
        send_frame(32'h0A0F, 15, 1'b0);
        send_frame(32'h14A0F, 17, 1'b0);
        send_frame(32'h0, 0, 1'b0);
        n_checks += 5;
        if (error_cnt - e0 != 3) begin n_fail++; $display("FAIL badlen error_pulses got %0d exp 3", error_cnt - e0); end
        if (valid_cnt - v0 != 0) begin n_fail++; $display("FAIL badlen valid_pulses got %0d exp 0", valid_cnt - v0); end
        if (intensity !== m_int) begin n_fail++; $display("FAIL badlen intensity got %0h exp %0h", intensity, m_int); end
        if (frame_addr !== m_faddr) begin n_fail++; $display("FAIL badlen frame_addr got %0h exp %0h", frame_addr, m_faddr); end
        if (frame_data !== m_fdata) begin n_fail++; $display("FAIL badlen frame_data got %0h exp %0h", frame_data, m_fdata); end
    endtask

    task automatic test_control();
        int v0 = valid_cnt;
        send_frame(32'h0C01, 16, 1'b0);
        send_frame(32'h0F01, 16, 1'b0);
        send_frame(32'h0000, 16, 1'b0);
        rd_addr = 3'd7;
        #1;
        n_checks += 6;
        if (shutdown_n !== 1'b1) begin n_fail++; $display("FAIL control shutdown_n got %0h exp 1", shutdown_n); end
        if (display_test !== 1'b1) begin n_fail++; $display("FAIL control display_test got %0h exp 1", display_test); end
        if (valid_cnt - v0 != 3) begin n_fail++; $display("FAIL control valid_pulses got %0d exp 3", valid_cnt - v0); end
        if (intensity !== m_int) begin n_fail++; $display("FAIL control intensity got %0h exp %0h", intensity, m_int); end
        if (rd_data !== m_digit[7]) begin n_fail++; $display("FAIL control digit7 got %0h exp %0h", rd_data, m_digit[7]); end
        if (frame_addr !== 4'h0) begin n_fail++; $display("FAIL control noop_addr got %0h exp 0", frame_addr); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        int e0;
        ncs = 1'b0;
        wait_clk(3);
        shift_bits(32'h0A, 8, 1'b0);
        rst = 1'b1;
        ncs = 1'b1;
        wait_clk(4);
        rst = 1'b0;
        model_reset();
        wait_clk(3);
        v0 = valid_cnt;
        e0 = error_cnt;
        send_frame(32'h0B07, 16, 1'b0);
        rd_addr = 3'd0;
        #1;
        n_checks += 5;
        if (intensity !== 4'h0) begin n_fail++; $display("FAIL midreset intensity got %0h exp 0", intensity); end
        if (scan_limit !== 3'h7) begin n_fail++; $display("FAIL midreset scan_limit got %0h exp 7", scan_limit); end
        if (error_cnt - e0 != 0) begin n_fail++; $display("FAIL midreset error_pulses got %0d exp 0", error_cnt - e0); end
        if (valid_cnt - v0 != 1) begin n_fail++; $display("FAIL midreset valid_pulses got %0d exp 1", valid_cnt - v0); end
        if (rd_data !== 8'h00) begin n_fail++; $display("FAIL midreset digit0 got %0h exp 0", rd_data); end
    endtask

    task automatic test_back_to_back();
        acc_q.delete();
        exp_q.delete();
        ncs = 1'b0;
        wait_clk(3);
        shift_bits(32'h0355, 16, 1'b0);
        ncs = 1'b1;
        wait_clk(1);
        ncs = 1'b0;
        model_frame(32'h0355, 16);
        wait_clk(3);
        shift_bits(32'h0B03, 16, 1'b0);
        ncs = 1'b1;
        wait_clk(8);
        model_frame(32'h0B03, 16);
        n_checks++;
        if (acc_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b accepted_count got %0d exp 2", acc_q.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b frame%0d got %0h exp %0h", i, acc_q[i], exp_q[i]); end
            end
        end
        rd_addr = 3'd2;
        #1;
        n_checks += 2;
        if (rd_data !== 8'h55) begin n_fail++; $display("FAIL b2b digit2 got %0h exp 55", rd_data); end
        if (scan_limit !== 3'h3) begin n_fail++; $display("FAIL b2b scan_limit got %0h exp 3", scan_limit); end
    endtask

    task automatic test_random();
        int v0 = valid_cnt;
        int e0 = error_cnt;
        int ev = 0;
        int ee = 0;
        acc_q.delete();
        exp_q.delete();
        for (int t = 0; t < 40; t++) begin
            int n;
            logic [31:0] bits;
            bit simul;
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : 16;
            bits = $urandom;
            simul = (n > 0) && ($urandom_range(0, 1) == 1);
            if (n == 16) ev++; else ee++;
            send_frame(bits, n, simul);
        end
        n_checks += 9;
        if (valid_cnt - v0 != ev) begin n_fail++; $display("FAIL random valid_pulses got %0d exp %0d", valid_cnt - v0, ev); end
        if (error_cnt - e0 != ee) begin n_fail++; $display("FAIL random error_pulses got %0d exp %0d", error_cnt - e0, ee); end
        if (decode_mode !== m_decode) begin n_fail++; $display("FAIL random decode_mode got %0h exp %0h", decode_mode, m_decode); end
        if (intensity !== m_int) begin n_fail++; $display("FAIL random intensity got %0h exp %0h", intensity, m_int); end
        if (scan_limit !== m_scan) begin n_fail++; $display("FAIL random scan_limit got %0h exp %0h", scan_limit, m_scan); end
        if (shutdown_n !== m_shut) begin n_fail++; $display("FAIL random shutdown_n got %0h exp %0h", shutdown_n, m_shut); end
        if (display_test !== m_test) begin n_fail++; $display("FAIL random display_test got %0h exp %0h", display_test, m_test); end
        if (frame_addr !== m_faddr) begin n_fail++; $display("FAIL random frame_addr got %0h exp %0h", frame_addr, m_faddr); end
        if (frame_data !== m_fdata) begin n_fail++; $display("FAIL random frame_data got %0h exp %0h", frame_data, m_fdata); end
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            n_checks++;
            if (rd_data !== m_digit[i]) begin n_fail++; $display("FAIL random digit%0d got %0h exp %0h", i, rd_data, m_digit[i]); end
        end
        n_checks++;
        if (acc_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL random accepted_count got %0d exp %0d", acc_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (acc_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random frame%0d got %0h exp %0h", i, acc_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_intensity();
        test_digits();
        test_bad_length();
        test_control();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
